gem_frame_sync_tracker: RTL and testbench

Parametrised GEM optical-link frame-synchronisation tracker. It monitors the per-fiber K-character frame separators from any number of OptoHybrids. It runs a per-fiber hunt/lock state machine against the BC→F7→FB→FD bunch-sequence cycle. It reports per-OH and super-chamber sync with sticky loss flags and per-fiber error counters. It sits after the GEM fiber receivers, feeding status registers and the GEM cluster-merging logic.

---
 rtl/gem_frame_sync_tracker.sv | 201 ++++++++++++++++++++
 tb/tb_gem_frame_sync_tracker.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_frame_sync_tracker.sv
// gem_frame_sync_tracker: per-fiber hunt/lock tracker for the GEM BC-F7-FB-FD
// separator cycle, with per-OH / super-chamber sync and sticky loss flags.
// Ports: clock, global_reset (async, active-high), ttc_resync, cnt_clear,
//   kchar[NFIBERS*8], link_good[NFIBERS], overflow[NOH] ->
//   fiber_locked[NFIBERS], oh_synced[NOH], all_synced, oh_lostsync[NOH],
//   all_lostsync, err_count[NFIBERS*ERRCNT_WIDTH].
// Define GEM_SYNC_ERRCNT_EN to build the saturating per-fiber error counters;
// without it err_count is tied to zero and cnt_clear has no effect.
module gem_frame_sync_tracker #(
  parameter int NFIBERS = 4,
  parameter int FIBERS_PER_OH = 2,
  parameter int LOCK_CNT = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int ERRCNT_WIDTH = 16,
  localparam int NOH = NFIBERS / FIBERS_PER_OH
) (
  input  logic clock,
  input  logic global_reset,
  input  logic ttc_resync,
  input  logic [NFIBERS*8-1:0] kchar,
  input  logic [NFIBERS-1:0] link_good,
  input  logic [NOH-1:0] overflow,
  input  logic cnt_clear,
  output logic [NFIBERS-1:0] fiber_locked,
  output logic [NOH-1:0] oh_synced,
  output logic all_synced,
  output logic [NOH-1:0] oh_lostsync,
  output logic all_lostsync,
  output logic [NFIBERS*ERRCNT_WIDTH-1:0] err_count
);

  localparam logic [7:0] K_BC = 8'hBC;
  localparam logic [7:0] K_F7 = 8'hF7;
  localparam logic [7:0] K_FB = 8'hFB;
  localparam logic [7:0] K_FD = 8'hFD;
  localparam logic [7:0] K_FC = 8'hFC;

  typedef enum logic {HUNT, LOCKED} state_t;

  function automatic logic [7:0] succ(input logic [7:0] c);
    logic [7:0] r;
    unique case (c)
      K_BC:    r = K_F7;
      K_F7:    r = K_FB;
      K_FB:    r = K_FD;
      default: r = K_BC;
    endcase
    return r;
  endfunction

  // next-cycle lock state: sync outputs are qualified by it
  logic [NFIBERS-1:0] lock_d;

  for (genvar i = 0; i < NFIBERS; i++) begin : g_fiber
    logic [7:0] k;
    logic       ov;
    logic       is_seq;
    logic       skip;
    logic       junk;
    logic       hit;
    logic       miss;
    state_t     st, st_d;
    logic [3:0] hcnt, hcnt_d;
    logic [3:0] ecnt, ecnt_d;
    logic [7:0] exp_q, exp_d;

    assign k  = kchar[8*i +: 8];
    assign ov = overflow[i / FIBERS_PER_OH];
    assign is_seq = (k == K_BC) || (k == K_F7) ||
                    (k == K_FB) || (k == K_FD);
    // overflow hides the char; FC marks an overflow slot
    assign skip = ov || (k == K_FC);
    assign junk = !skip && !is_seq;
    assign hit  = !skip && (k == exp_q);

    always_comb begin
      st_d   = st;
      hcnt_d = hcnt;
      ecnt_d = ecnt;
      exp_d  = exp_q;
      miss   = 1'b0;
      if (ttc_resync) begin
        st_d   = HUNT;
        hcnt_d = 4'd0;
        ecnt_d = 4'd0;
        exp_d  = K_BC;
      end else if (!link_good[i]) begin
        st_d   = HUNT;
        hcnt_d = 4'd0;
      end else if (st == HUNT) begin
        unique case (1'b1)
          skip:    exp_d = succ(exp_q);
          junk:    hcnt_d = 4'd0;
          default: begin
            exp_d  = succ(k);
            hcnt_d = (hit && hcnt != 4'd0) ?
                     hcnt + 4'd1 : 4'd1;
          end
        endcase
        if (hcnt_d == 4'(LOCK_CNT)) begin
          st_d   = LOCKED;
          ecnt_d = 4'd0;
        end
      end else begin
        // phase keeps running even across a bad char
        exp_d = succ(exp_q);
        if (skip || hit) begin
          ecnt_d = 4'd0;
        end else begin
          miss   = 1'b1;
          ecnt_d = ecnt + 4'd1;
          if (ecnt_d == 4'(UNLOCK_ERRS)) begin
            st_d   = HUNT;
            hcnt_d = 4'd0;
          end
        end
      end
    end

    always_ff @(posedge clock or posedge global_reset) begin
      if (global_reset) begin
        st    <= HUNT;
        hcnt  <= 4'd0;
        ecnt  <= 4'd0;
        exp_q <= K_BC;
      end else begin
        st    <= st_d;
        hcnt  <= hcnt_d;
        ecnt  <= ecnt_d;
        exp_q <= exp_d;
      end
    end

    assign lock_d[i]       = (st_d == LOCKED);
    assign fiber_locked[i] = (st == LOCKED);

`ifdef GEM_SYNC_ERRCNT_EN
    logic [ERRCNT_WIDTH-1:0] errc;

    always_ff @(posedge clock or posedge global_reset) begin
      if (global_reset) begin
        errc <= '0;
      end else if (cnt_clear) begin
        errc <= '0;
      end else if (miss && !(&errc)) begin
        errc <= errc + 1'b1;
      end
    end

    assign err_count[i*ERRCNT_WIDTH +: ERRCNT_WIDTH] = errc;
`else
    logic unused_errc;
    assign unused_errc = miss ^ cnt_clear;
    assign err_count[i*ERRCNT_WIDTH +: ERRCNT_WIDTH] = '0;
`endif
  end

  logic [NOH-1:0] oh_eq;
  logic           f0_eq;
  logic [NOH-1:0] oh_d;
  logic           all_d;

  always_comb begin
    oh_eq = '1;
    f0_eq = 1'b1;
    for (int f = 0; f < NFIBERS; f++) begin
      if (kchar[8*f +: 8] !=
          kchar[8*(f - f % FIBERS_PER_OH) +: 8])
        oh_eq[f / FIBERS_PER_OH] = 1'b0;
      if ((f % FIBERS_PER_OH == 0) &&
          (kchar[8*f +: 8] != kchar[7:0]))
        f0_eq = 1'b0;
    end
    oh_d = '0;
    for (int o = 0; o < NOH; o++) begin
      oh_d[o] = (&lock_d[o*FIBERS_PER_OH +: FIBERS_PER_OH]) &&
                (overflow[o] || oh_eq[o]);
    end
    all_d = (&oh_d) && ((|overflow) || f0_eq);
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      oh_synced    <= '0;
      all_synced   <= 1'b0;
      oh_lostsync  <= '0;
      all_lostsync <= 1'b0;
    end else if (ttc_resync) begin
      oh_synced    <= '0;
      all_synced   <= 1'b0;
      oh_lostsync  <= '0;
      all_lostsync <= 1'b0;
    end else begin
      oh_synced    <= oh_d;
      all_synced   <= all_d;
      oh_lostsync  <= oh_lostsync | (oh_synced & ~oh_d);
      all_lostsync <= all_lostsync | (all_synced & ~all_d);
    end
  end

endmodule

// File: tb/tb_gem_frame_sync_tracker.sv
// tb_gem_frame_sync_tracker: directed + random stimulus for the frame sync
// tracker, compared every cycle against a behavioural sequence model.
module tb_gem_frame_sync_tracker;

  localparam int NF  = 4;
  localparam int FPO = 2;
  localparam int NOH = NF / FPO;
  localparam int LOCK = 4;
  localparam int UNL  = 3;
  localparam int EW   = 4;
  localparam int ERRMAX = (1 << EW) - 1;
`ifdef GEM_SYNC_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [7:0] SEQ [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};

  logic clock;
  logic global_reset;
  logic ttc_resync;
  logic [NF*8-1:0] kchar;
  logic [NF-1:0] link_good;
  logic [NOH-1:0] overflow;
  logic cnt_clear;
  logic [NF-1:0] fiber_locked;
  logic [NOH-1:0] oh_synced;
  logic all_synced;
  logic [NOH-1:0] oh_lostsync;
  logic all_lostsync;
  logic [NF*EW-1:0] err_count;

  gem_frame_sync_tracker #(
    .NFIBERS(NF), .FIBERS_PER_OH(FPO), .LOCK_CNT(LOCK),
    .UNLOCK_ERRS(UNL), .ERRCNT_WIDTH(EW)
  ) dut (
    .clock(clock), .global_reset(global_reset),
    .ttc_resync(ttc_resync), .kchar(kchar),
    .link_good(link_good), .overflow(overflow),
    .cnt_clear(cnt_clear), .fiber_locked(fiber_locked),
    .oh_synced(oh_synced), .all_synced(all_synced),
    .oh_lostsync(oh_lostsync), .all_lostsync(all_lostsync),
    .err_count(err_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, want, $time);
    end
  endtask

  function automatic int erx(input int n);
    return ERR_EN ? n : 0;
  endfunction

  // ---------------- behavioural model ----------------
  // each fiber: phase index of next expected char (0..3),
  // run length while hunting, error streak while locked
  bit m_lock [NF];
  int m_h [NF];
  int m_e [NF];
  int m_x [NF];
  int m_err [NF];
  bit m_oh [NOH];
  bit m_ohl [NOH];
  bit m_all, m_alll;

  function automatic int pos(input logic [7:0] c);
    for (int j = 0; j < 4; j++)
      if (c == SEQ[j]) return j;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_lock[i] = 0; m_h[i] = 0; m_e[i] = 0;
      m_x[i] = 0; m_err[i] = 0;
    end
    for (int o = 0; o < NOH; o++) begin
      m_oh[o] = 0; m_ohl[o] = 0;
    end
    m_all = 0; m_alll = 0;
  endtask

  task automatic model_step();
    logic [7:0] c;
    int p;
    bit ov, miss, lk, eq, na, f0;
    bit noh [NOH];
    for (int i = 0; i < NF; i++) begin
      c = kchar[8*i +: 8];
      p = pos(c);
      ov = overflow[i / FPO];
      miss = 0;
      if (ttc_resync) begin
        m_lock[i] = 0; m_h[i] = 0; m_e[i] = 0; m_x[i] = 0;
      end else if (!link_good[i]) begin
        m_lock[i] = 0; m_h[i] = 0;
      end else if (!m_lock[i]) begin
        if (ov || c == 8'hFC) m_x[i] = (m_x[i] + 1) % 4;
        else if (p < 0) m_h[i] = 0;
        else begin
          m_h[i] = (p == m_x[i] && m_h[i] > 0) ? m_h[i] + 1 : 1;
          m_x[i] = (p + 1) % 4;
        end
        if (m_h[i] == LOCK) begin
          m_lock[i] = 1; m_e[i] = 0;
        end
      end else begin
        miss = !(ov || c == 8'hFC || p == m_x[i]);
        m_x[i] = (m_x[i] + 1) % 4;
        m_e[i] = miss ? m_e[i] + 1 : 0;
        if (m_e[i] == UNL) begin
          m_lock[i] = 0; m_h[i] = 0;
        end
      end
      if (cnt_clear) m_err[i] = 0;
      else if (miss && m_err[i] < ERRMAX) m_err[i]++;
    end
    na = 1; f0 = 1;
    for (int o = 0; o < NOH; o++) begin
      lk = 1; eq = 1;
      for (int j = 0; j < FPO; j++) begin
        lk &= m_lock[o*FPO + j];
        if (kchar[8*(o*FPO + j) +: 8] != kchar[8*o*FPO +: 8]) eq = 0;
      end
      if (kchar[8*o*FPO +: 8] != kchar[7:0]) f0 = 0;
      noh[o] = !ttc_resync && lk && (overflow[o] || eq);
      na &= noh[o];
    end
    na = na && ((|overflow) || f0);
    for (int o = 0; o < NOH; o++) begin
      m_ohl[o] = ttc_resync ? 0 : (m_ohl[o] | (m_oh[o] & !noh[o]));
      m_oh[o] = noh[o];
    end
    m_alll = ttc_resync ? 0 : (m_alll | (m_all & !na));
    m_all = na;
  endtask

  always @(posedge clock or posedge global_reset) begin
    if (global_reset) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (check_en) begin
      logic [NF-1:0] el;
      logic [NOH-1:0] eo, eol;
      logic [NF*EW-1:0] ee;
      for (int i = 0; i < NF; i++) begin
        el[i] = m_lock[i];
        ee[i*EW +: EW] = ERR_EN ? EW'(m_err[i]) : '0;
      end
      for (int o = 0; o < NOH; o++) begin
        eo[o] = m_oh[o];
        eol[o] = m_ohl[o];
      end
      chk("fiber_locked", 64'(fiber_locked), 64'(el));
      chk("oh_synced", 64'(oh_synced), 64'(eo));
      chk("all_synced", 64'(all_synced), 64'(m_all));
      chk("oh_lostsync", 64'(oh_lostsync), 64'(eol));
      chk("all_lostsync", 64'(all_lostsync), 64'(m_alll));
      chk("err_count", 64'(err_count), 64'(ee));
    end
  end

  // ---------------- stimulus ----------------
  int ph [NF];
  logic [7:0] ovr [NF];
  bit ovr_en [NF];

  task automatic drive();
    for (int i = 0; i < NF; i++) begin
      kchar[8*i +: 8] = ovr_en[i] ? ovr[i] : SEQ[ph[i]];
      ph[i] = (ph[i] + 1) % 4;
    end
    @(negedge clock);
    for (int i = 0; i < NF; i++) ovr_en[i] = 0;
    ttc_resync = 0;
    cnt_clear = 0;
  endtask

  task automatic clean(input int n);
    repeat (n) drive();
  endtask

  initial begin
    global_reset = 1; ttc_resync = 0; cnt_clear = 0;
    kchar = '0; link_good = '0; overflow = '0;
    for (int i = 0; i < NF; i++) begin
      ph[i] = 0; ovr[i] = 8'h00; ovr_en[i] = 0;
    end
    repeat (2) @(negedge clock);
    chk("rst_locked", 64'(fiber_locked), 64'h0);
    chk("rst_oh", 64'(oh_synced), 64'h0);
    chk("rst_all", 64'(all_synced), 64'h0);
    chk("rst_err", 64'(err_count), 64'h0);
    global_reset = 0;
    check_en = 1;
    link_good = '1;

    // lock acquisition
    clean(3);
    chk("acq_early", 64'(fiber_locked), 64'h0);
    clean(1);
    chk("acq_locked", 64'(fiber_locked), 64'hF);
    chk("acq_oh", 64'(oh_synced), 64'h3);
    chk("acq_all", 64'(all_synced), 64'h1);
    chk("acq_err", 64'(err_count), 64'h0);

    // loss and re-lock on fiber 1
    for (int n = 0; n < 3; n++) begin
      ovr[1] = 8'h00; ovr_en[1] = 1; drive();
    end
    chk("loss_locked", 64'(fiber_locked), 64'hD);
    chk("loss_oh", 64'(oh_synced), 64'h2);
    chk("loss_ohl", 64'(oh_lostsync), 64'h1);
    chk("loss_alll", 64'(all_lostsync), 64'h1);
    chk("loss_err1", 64'(err_count[EW +: EW]), 64'(erx(3)));
    clean(4);
    chk("relock", 64'(fiber_locked), 64'hF);
    chk("relock_all", 64'(all_synced), 64'h1);
    chk("relock_ohl", 64'(oh_lostsync), 64'h1);
    chk("relock_alll", 64'(all_lostsync), 64'h1);

    // transient error on fiber 0
    ovr[0] = SEQ[(ph[0] + 3) % 4]; ovr_en[0] = 1; drive();
    clean(4);
    chk("trans_locked", 64'(fiber_locked), 64'hF);
    chk("trans_err0", 64'(err_count[0 +: EW]), 64'(erx(1)));

    // overflow bypass on OH 1
    overflow = 2'b10;
    for (int n = 0; n < 5; n++) begin
      for (int i = 2; i < 4; i++) begin
        ovr[i] = $urandom_range(0, 1) ? 8'hFC : 8'($urandom);
        ovr_en[i] = 1;
      end
      drive();
    end
    chk("ovf_locked", 64'(fiber_locked), 64'hF);
    chk("ovf_oh", 64'(oh_synced), 64'h3);
    chk("ovf_err23", 64'(err_count[2*EW +: 2*EW]), 64'h0);
    overflow = '0;
    clean(2);

    // skew: fiber 0 one step ahead of fiber 1
    ph[0] = (ph[0] + 1) % 4;
    clean(10);
    chk("skew_locked", 64'(fiber_locked[1:0]), 64'h3);
    chk("skew_oh0", 64'(oh_synced[0]), 64'h0);
    chk("skew_all", 64'(all_synced), 64'h0);
    ph[0] = (ph[0] + 3) % 4;
    clean(10);
    chk("unskew", 64'(fiber_locked), 64'hF);

    // resync and clear
    ttc_resync = 1; drive();
    chk("rsy_locked", 64'(fiber_locked), 64'h0);
    chk("rsy_oh", 64'(oh_synced), 64'h0);
    chk("rsy_all", 64'(all_synced), 64'h0);
    chk("rsy_ohl", 64'(oh_lostsync), 64'h0);
    chk("rsy_alll", 64'(all_lostsync), 64'h0);
    clean(4);
    chk("rsy_relock", 64'(fiber_locked), 64'hF);
    ovr[0] = 8'h00; ovr_en[0] = 1; cnt_clear = 1; drive();
    chk("clr_err", 64'(err_count), 64'h0);
    clean(4);

    // saturation: 6 rounds of 3 errors each
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 3; n++) begin
        ovr[0] = 8'h00; ovr_en[0] = 1; drive();
      end
      clean(4);
    end
    chk("sat_err0", 64'(err_count[0 +: EW]), 64'(erx(ERRMAX)));
    chk("sat_locked", 64'(fiber_locked), 64'hF);

    // asynchronous reset between edges
    #2 global_reset = 1;
    #1;
    chk("arst_locked", 64'(fiber_locked), 64'h0);
    chk("arst_oh", 64'(oh_synced), 64'h0);
    chk("arst_flags", 64'({oh_lostsync, all_lostsync}), 64'h0);
    chk("arst_err", 64'(err_count), 64'h0);
    @(negedge clock);
    global_reset = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NF; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 85) ovr_en[i] = 0;
        else if (r < 90) begin
          ovr[i] = 8'($urandom); ovr_en[i] = 1;
        end else if (r < 94) begin
          ovr[i] = SEQ[(ph[i] + $urandom_range(1, 3)) % 4];
          ovr_en[i] = 1;
        end else if (r < 97) begin
          ovr[i] = 8'hFC; ovr_en[i] = 1;
        end else ph[i] = (ph[i] + 1) % 4;
        link_good[i] = ($urandom_range(0, 99) >= 2);
      end
      for (int o = 0; o < NOH; o++)
        overflow[o] = ($urandom_range(0, 99) < 3);
      ttc_resync = ($urandom_range(0, 199) == 0);
      cnt_clear = ($urandom_range(0, 99) == 0);
      drive();
    end

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
